// File: rtl/part1_mac.sv
// Signed multiply-accumulate: one registered operand stage, then a running sum
// that advances only on qualified products and otherwise holds.
module part1_mac #(
    parameter int IN_W  = 10,
    parameter int OUT_W = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  a,
    input  logic [IN_W-1:0]  b,
    input  logic             valid_in,
    output logic [OUT_W-1:0] f,
    output logic             valid_out
);

    logic signed [IN_W-1:0]  a_q, b_q;
    logic                    en_q;
    logic signed [OUT_W-1:0] f_q, f_d;
    logic                    vld_q;
    logic signed [OUT_W-1:0] a_x, b_x, prod;

    // Sign-extend before multiplying so the full product lands in OUT_W bits.
    assign a_x  = OUT_W'(a_q);
    assign b_x  = OUT_W'(b_q);
    assign prod = a_x * b_x;

    always_comb begin
        f_d = f_q;
        if (en_q) f_d = f_q + prod;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q   <= '0;
            b_q   <= '0;
            en_q  <= 1'b0;
            f_q   <= '0;
            vld_q <= 1'b0;
        end else begin
            a_q   <= a;
            b_q   <= b;
            en_q  <= valid_in;
            f_q   <= f_d;
            vld_q <= en_q;
        end
    end

    assign f         = f_q;
    assign valid_out = vld_q;

endmodule

// File: tb/tb_part1_mac.sv
// Directed bench for part1_mac: hand-computed sums checked 1ns after each posedge.
module tb_part1_mac;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  a = '0, b = '0;
    logic        valid_in = 1'b0;
    logic [19:0] f;
    logic        valid_out;

    int n_chk  = 0;
    int n_fail = 0;

    part1_mac #(.IN_W(10), .OUT_W(20)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in),
        .f(f), .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic chk_out(input string tag, input logic vo, input int fexp);
        logic [19:0] fe;
        fe = 20'(fexp);
        chk({tag, ".valid_out"}, {31'd0, valid_out}, {31'd0, vo});
        chk({tag, ".f"}, {12'd0, f}, {12'd0, fe});
    endtask

    task automatic step(input int av, input int bv, input logic v);
        a = 10'(av);
        b = 10'(bv);
        valid_in = v;
        @(posedge clk);
        #1;
    endtask

    // Reset asserted 1ns after an edge, checked before any further clock edge.
    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        chk_out(tag, 1'b0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        valid_in = 1'b0;
    endtask

    initial begin
        // async reset with no clock edge
        #2;
        do_reset("rst_async");

        // basic accumulate with gaps
        step(0, 0, 0); chk_out("seq_p1", 1'b0, 0);
        step(1, 1, 0); chk_out("seq_p2", 1'b0, 0);
        step(2, 2, 1); chk_out("seq_p3", 1'b0, 0);
        step(3, 3, 1); chk_out("seq_p4", 1'b1, 4);
        step(4, 4, 0); chk_out("seq_p5", 1'b1, 13);
        step(5, 5, 0); chk_out("seq_p6", 1'b0, 13);
        step(6, 6, 1); chk_out("seq_p7", 1'b0, 13);
        step(0, 0, 0); chk_out("seq_p8", 1'b1, 49);

        // signed extremes
        do_reset("rst_signed");
        step(-512, -512, 1);
        step(-3, 7, 1);     chk_out("neg_min", 1'b1, 262144);
        step(0, 0, 0);      chk_out("neg_mix", 1'b1, 262123);

        // modulo-2^20 wrap of 511*511 repeated
        do_reset("rst_wrap");
        step(511, 511, 1);
        step(511, 511, 1);  chk_out("wrap1", 1'b1, 261121);
        step(511, 511, 1);  chk_out("wrap2", 1'b1, 522242);
        step(511, 511, 1);  chk_out("wrap3", 1'b1, -265213);
        step(511, 511, 1);  chk_out("wrap4", 1'b1, -4092);
        step(0, 0, 0);      chk_out("wrap5", 1'b1, 257029);
        step(0, 0, 0);      chk_out("wrap_idle", 1'b0, 257029);

        // reset while a valid operand sits in stage 1
        step(9, 9, 1);
        do_reset("rst_mid");
        step(0, 0, 0);      chk_out("mid_nopost", 1'b0, 0);
        step(2, 5, 1);      chk_out("mid_pre", 1'b0, 0);
        step(0, 0, 0);      chk_out("mid_post", 1'b1, 10);

        // long idle
        for (int i = 0; i < 10; i++) begin
            step(i + 100, 77, 0);
            chk_out($sformatf("idle%0d", i), 1'b0, 10);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
